// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light sequencer: phase states,
// lamp encodings and the one-byte phase duration type.
package traffic_pkg;

  typedef enum logic [2:0] {
    MG  = 3'd0,
    MY  = 3'd1,
    AR1 = 3'd2,
    SG  = 3'd3,
    SY  = 3'd4,
    AR2 = 3'd5
  } state_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  typedef logic [7:0] dur_t;

  // Durations are clamped into 1..255 so a zero setting still lasts one tick.
  function automatic dur_t to_dur(input int seconds);
    if (seconds <= 0)
      return 8'd1;
    else if (seconds > 255)
      return 8'd255;
    else
      return dur_t'(seconds);
  endfunction

  function automatic logic [2:0] main_lamp_of(input state_t s);
    case (s)
      MG:      return LAMP_GRN;
      MY:      return LAMP_YEL;
      default: return LAMP_RED;
    endcase
  endfunction

  function automatic logic [2:0] side_lamp_of(input state_t s);
    case (s)
      SG:      return LAMP_GRN;
      SY:      return LAMP_YEL;
      default: return LAMP_RED;
    endcase
  endfunction

endpackage

// File: rtl/light_sequencer_if.sv
// Bundles the timebase, request inputs and lamp outputs of the sequencer.
// The slave side is the sequencer itself; the master side drives requests.
interface light_sequencer_if;
  import traffic_pkg::*;

  logic       OneHz;
  logic       side_sensor;
  logic       ped_button;
  logic [2:0] main_lamp;
  logic [2:0] side_lamp;
  logic       walk;
  dur_t       seconds_left;

  modport master (
    output OneHz, side_sensor, ped_button,
    input  main_lamp, side_lamp, walk, seconds_left
  );

  modport slave (
    input  OneHz, side_sensor, ped_button,
    output main_lamp, side_lamp, walk, seconds_left
  );

endinterface

// File: rtl/tick_detect.sv
// Turns the OneHz square wave into a single-cycle tick on each rising edge.
module tick_detect (
  input  logic clk,
  input  logic Sync_Reset,
  input  logic OneHz,
  output logic tick
);

  logic onehz_q;

  // Resetting to 1 means a OneHz already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (Sync_Reset)
      onehz_q <= 1'b1;
    else
      onehz_q <= OneHz;
  end

  assign tick = OneHz & ~onehz_q;

endmodule

// File: rtl/light_sequencer.sv
// Two-road traffic-light phase sequencer stepped by one-second ticks, with
// latched side-road and pedestrian requests and fully registered outputs.
module light_sequencer
  import traffic_pkg::*;
#(
  parameter int MAIN_GREEN_S = 8,
  parameter int SIDE_GREEN_S = 5,
  parameter int YELLOW_S     = 2,
  parameter int ALL_RED_S    = 1
) (
  input  logic               clk,
  input  logic               Sync_Reset,
  light_sequencer_if.slave   lights
);

  localparam dur_t MG_D  = to_dur(MAIN_GREEN_S);
  localparam dur_t SG_D  = to_dur(SIDE_GREEN_S);
  localparam dur_t YEL_D = to_dur(YELLOW_S);
  localparam dur_t AR_D  = to_dur(ALL_RED_S);

  logic   tick;
  state_t state, next_state;
  dur_t   cnt, next_cnt;
  logic   side_req, ped_req;
  logic   enter_sg;

  tick_detect u_tick (
    .clk        (clk),
    .Sync_Reset (Sync_Reset),
    .OneHz      (lights.OneHz),
    .tick       (tick)
  );

  // A terminal tick loads the following phase and its duration on the same edge.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    if (tick) begin
      if (cnt <= 8'd1) begin
        case (state)
          MG: begin
            if (side_req || ped_req) begin
              next_state = MY;
              next_cnt   = YEL_D;
            end else begin
              next_cnt = MG_D;
            end
          end
          MY:  begin next_state = AR1; next_cnt = AR_D;  end
          AR1: begin next_state = SG;  next_cnt = SG_D;  end
          SG:  begin next_state = SY;  next_cnt = YEL_D; end
          SY:  begin next_state = AR2; next_cnt = AR_D;  end
          AR2: begin next_state = MG;  next_cnt = MG_D;  end
          default: begin next_state = MG; next_cnt = MG_D; end
        endcase
      end else begin
        next_cnt = cnt - 8'd1;
      end
    end
  end

  assign enter_sg = (next_state == SG) && (state != SG);

  // Outputs are derived from the next state so they change on the same edge
  // as the phase; walk captures ped_req at SG entry and holds through SG.
  always_ff @(posedge clk) begin
    if (Sync_Reset) begin
      state               <= MG;
      cnt                 <= MG_D;
      side_req            <= 1'b0;
      ped_req             <= 1'b0;
      lights.main_lamp    <= LAMP_GRN;
      lights.side_lamp    <= LAMP_RED;
      lights.walk         <= 1'b0;
      lights.seconds_left <= MG_D;
    end else begin
      state               <= next_state;
      cnt                 <= next_cnt;
      lights.seconds_left <= next_cnt;
      lights.main_lamp    <= main_lamp_of(next_state);
      lights.side_lamp    <= side_lamp_of(next_state);
      if (enter_sg) begin
        side_req    <= 1'b0;
        ped_req     <= 1'b0;
        lights.walk <= ped_req;
      end else begin
        side_req    <= side_req | lights.side_sensor;
        ped_req     <= ped_req | lights.ped_button;
        lights.walk <= lights.walk && (next_state == SG);
      end
    end
  end

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer with short phase durations; each task
// drives one scenario and compares registered outputs against hand values.
module tb_light_sequencer;
  import traffic_pkg::*;

  logic clk = 1'b0;
  logic Sync_Reset = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  light_sequencer_if lif ();

  light_sequencer #(
    .MAIN_GREEN_S (4),
    .SIDE_GREEN_S (3),
    .YELLOW_S     (2),
    .ALL_RED_S    (1)
  ) dut (
    .clk        (clk),
    .Sync_Reset (Sync_Reset),
    .lights     (lif.slave)
  );

  always #5 clk = ~clk;

  // Expected {main_lamp, side_lamp, seconds_left} after ticks 1..13 of a
  // full cycle starting from reset with a request pending before tick 4.
  logic [2:0] exp_main [13] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100,
                                3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
  logic [2:0] exp_side [13] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001,
                                3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
  logic [7:0] exp_secs [13] = '{8'd3, 8'd2, 8'd1, 8'd2, 8'd1, 8'd1, 8'd3,
                                8'd2, 8'd1, 8'd2, 8'd1, 8'd1, 8'd4};

  task automatic do_reset();
    @(negedge clk);
    lif.OneHz = 1'b0;
    lif.side_sensor = 1'b0;
    lif.ped_button = 1'b0;
    Sync_Reset = 1'b1;
    @(negedge clk);
    Sync_Reset = 1'b0;
  endtask

  // One full OneHz period; returns at a negedge with exactly one tick consumed.
  task automatic one_second();
    @(negedge clk);
    lif.OneHz = 1'b1;
    repeat (5) @(negedge clk);
    lif.OneHz = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse_side();
    @(negedge clk);
    lif.side_sensor = 1'b1;
    @(negedge clk);
    lif.side_sensor = 1'b0;
  endtask

  task automatic test_reset();
    logic [14:0] obs;
    do_reset();
    obs = {lif.main_lamp, lif.side_lamp, lif.walk, lif.seconds_left};
    tests_run++;
    if (obs !== {3'b001, 3'b100, 1'b0, 8'd4}) begin
      tests_failed++;
      $display("[TB] FAIL reset_values got=%h want=%h", obs, {3'b001, 3'b100, 1'b0, 8'd4});
    end
  endtask

  task automatic test_idle();
    logic [7:0] want;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      one_second();
      want = (k % 4 == 0) ? 8'd4 : 8'(4 - (k % 4));
      tests_run++;
      if ({lif.main_lamp, lif.seconds_left} !== {3'b001, want}) begin
        tests_failed++;
        $display("[TB] FAIL idle_tick%0d got main=%b secs=%0d want main=001 secs=%0d",
                 k, lif.main_lamp, lif.seconds_left, want);
      end
    end
  endtask

  task automatic test_side_cycle();
    logic [14:0] obs, want;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      if (i == 1) pulse_side();
      one_second();
      obs  = {lif.main_lamp, lif.side_lamp, lif.walk, lif.seconds_left};
      want = {exp_main[i], exp_side[i], 1'b0, exp_secs[i]};
      tests_run++;
      if (obs !== want) begin
        tests_failed++;
        $display("[TB] FAIL side_cycle_tick%0d got=%h want=%h", i + 1, obs, want);
      end
    end
  endtask

  task automatic test_ped_walk();
    logic [14:0] obs, want;
    do_reset();
    @(negedge clk);
    lif.ped_button = 1'b1;
    @(negedge clk);
    lif.ped_button = 1'b0;
    for (int i = 0; i < 13; i++) begin
      one_second();
      obs  = {lif.main_lamp, lif.side_lamp, lif.walk, lif.seconds_left};
      want = {exp_main[i], exp_side[i], (i >= 6 && i <= 8), exp_secs[i]};
      tests_run++;
      if (obs !== want) begin
        tests_failed++;
        $display("[TB] FAIL ped_walk_tick%0d got=%h want=%h", i + 1, obs, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] obs, want;
    do_reset();
    pulse_side();
    repeat (10) one_second();
    pulse_side();
    for (int k = 11; k <= 17; k++) begin
      one_second();
      if (k >= 13) begin
        obs  = {lif.main_lamp, lif.seconds_left};
        want = (k == 17) ? {3'b010, 8'd2} : {3'b001, 8'(17 - k)};
        tests_run++;
        if (obs !== want) begin
          tests_failed++;
          $display("[TB] FAIL rerequest_tick%0d got=%h want=%h", k, obs, want);
        end
      end
    end
  endtask

  task automatic test_reset_mid_sg();
    logic [14:0] obs;
    do_reset();
    @(negedge clk);
    lif.side_sensor = 1'b1;
    lif.ped_button = 1'b1;
    @(negedge clk);
    lif.side_sensor = 1'b0;
    lif.ped_button = 1'b0;
    repeat (7) one_second();
    obs = {lif.main_lamp, lif.side_lamp, lif.walk, lif.seconds_left};
    tests_run++;
    if (obs !== {3'b100, 3'b001, 1'b1, 8'd3}) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_sg got=%h want=%h", obs, {3'b100, 3'b001, 1'b1, 8'd3});
    end
    // Requests were cleared at SG entry; raise them again so reset must clear them.
    lif.side_sensor = 1'b1;
    lif.ped_button = 1'b1;
    @(negedge clk);
    lif.side_sensor = 1'b0;
    lif.ped_button = 1'b0;
    Sync_Reset = 1'b1;
    @(negedge clk);
    Sync_Reset = 1'b0;
    obs = {lif.main_lamp, lif.side_lamp, lif.walk, lif.seconds_left};
    tests_run++;
    if (obs !== {3'b001, 3'b100, 1'b0, 8'd4}) begin
      tests_failed++;
      $display("[TB] FAIL mid_sg_reset got=%h want=%h", obs, {3'b001, 3'b100, 1'b0, 8'd4});
    end
    repeat (5) one_second();
    tests_run++;
    if ({lif.main_lamp, lif.seconds_left} !== {3'b001, 8'd3}) begin
      tests_failed++;
      $display("[TB] FAIL reqs_cleared got main=%b secs=%0d want main=001 secs=3",
               lif.main_lamp, lif.seconds_left);
    end
  endtask

  task automatic test_onehz_held_high();
    @(negedge clk);
    lif.OneHz = 1'b1;
    Sync_Reset = 1'b1;
    @(negedge clk);
    Sync_Reset = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      repeat (10) @(negedge clk);
      tests_run++;
      if (lif.seconds_left !== 8'd4) begin
        tests_failed++;
        $display("[TB] FAIL held_high_%0d got=%0d want=4", c * 10, lif.seconds_left);
      end
    end
    lif.OneHz = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++;
    if (lif.seconds_left !== 8'd4) begin
      tests_failed++;
      $display("[TB] FAIL held_low got=%0d want=4", lif.seconds_left);
    end
    lif.OneHz = 1'b1;
    @(negedge clk);
    tests_run++;
    if (lif.seconds_left !== 8'd3) begin
      tests_failed++;
      $display("[TB] FAIL first_edge got=%0d want=3", lif.seconds_left);
    end
    lif.OneHz = 1'b0;
  endtask

  initial begin
    lif.OneHz = 1'b0;
    lif.side_sensor = 1'b0;
    lif.ped_button = 1'b0;
    test_reset();
    test_idle();
    test_side_cycle();
    test_ped_walk();
    test_back_to_back();
    test_reset_mid_sg();
    test_onehz_held_high();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
